// File: rtl/find_blob_centroids.sv
// find_blob_centroids: groups lit pixels of a binarised camera stream into up
// to N_BLOBS blobs by run-length merging, then divides each kept blob's sums by
// its pixel count at frame end and publishes a compacted centroid list.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SCAN    | track runs on the pixel stream, merge closed runs into slots
// DIV     | visit slots in order; skip small/empty, divide kept ones
// PUBLISH | copy staged centroids to the outputs, pulse o_FRAME_VALID
// CLEAR   | empty all slots and the frame overflow flag, back to SCAN
module find_blob_centroids #(
    parameter int N_BLOBS    = 4,
    parameter int W          = 16,
    parameter int ACC_W      = 32,
    parameter int MERGE_GAP  = 2,
    parameter int MIN_PIXELS = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 VGA_HS,
    input  logic                 VGA_VS,
    input  logic                 BINARY_FLAG,
    input  logic [W-1:0]         H_CNT,
    input  logic [W-1:0]         V_CNT,
    output logic [N_BLOBS*W-1:0] o_POINTS_H,
    output logic [N_BLOBS*W-1:0] o_POINTS_V,
    output logic [7:0]           o_POINTS_NUM,
    output logic                 o_FRAME_VALID,
    output logic                 o_OVERFLOW,
    output logic                 o_BUSY
);

    localparam int IDX_W = (N_BLOBS > 1) ? $clog2(N_BLOBS) : 1;
    localparam int K_W   = $clog2(N_BLOBS + 1);
    localparam int BIT_W = $clog2(ACC_W + 1);
    localparam logic [W-1:0]     GAP_V    = W'(MERGE_GAP);
    localparam logic [W:0]       GAP_X    = (W+1)'(MERGE_GAP);
    localparam logic [ACC_W-1:0] MIN_CNT  = ACC_W'(MIN_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BLOBS - 1);
    localparam logic [BIT_W-1:0] DIV_BITS = BIT_W'(ACC_W);

    typedef enum logic [1:0] {S_SCAN, S_DIV, S_PUBLISH, S_CLEAR} state_t;

    // Accumulators stick at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // One restoring-division step; returns {remainder, quotient}.
    function automatic logic [2*ACC_W-1:0] div_step(input logic [ACC_W-1:0] rem,
                                                    input logic [ACC_W-1:0] quo,
                                                    input logic [ACC_W-1:0] den);
        logic [ACC_W:0] sh;
        logic           qbit;
        sh = {rem, quo[ACC_W-1]};
        if (sh >= {1'b0, den}) begin
            sh   = sh - {1'b0, den};
            qbit = 1'b1;
        end else begin
            qbit = 1'b0;
        end
        return {sh[ACC_W-1:0], quo[ACC_W-2:0], qbit};
    endfunction

    state_t state_q, state_d;

    logic hs_q, vs_q, flag_q;
    logic hs_fall, vs_fall, flag_fall;

    logic             run_open_q, run_open_d;
    logic [W-1:0]     run_rs_q, run_rs_d, run_re_q, run_re_d, run_v_q, run_v_d;
    logic [ACC_W-1:0] run_sum_h_q, run_sum_h_d, run_sum_v_q, run_sum_v_d;
    logic [ACC_W-1:0] run_cnt_q, run_cnt_d;

    logic             slot_valid_q [N_BLOBS];
    logic             slot_valid_d [N_BLOBS];
    logic [W-1:0]     slot_min_h_q [N_BLOBS];
    logic [W-1:0]     slot_min_h_d [N_BLOBS];
    logic [W-1:0]     slot_max_h_q [N_BLOBS];
    logic [W-1:0]     slot_max_h_d [N_BLOBS];
    logic [W-1:0]     slot_max_v_q [N_BLOBS];
    logic [W-1:0]     slot_max_v_d [N_BLOBS];
    logic [ACC_W-1:0] slot_sum_h_q [N_BLOBS];
    logic [ACC_W-1:0] slot_sum_h_d [N_BLOBS];
    logic [ACC_W-1:0] slot_sum_v_q [N_BLOBS];
    logic [ACC_W-1:0] slot_sum_v_d [N_BLOBS];
    logic [ACC_W-1:0] slot_cnt_q   [N_BLOBS];
    logic [ACC_W-1:0] slot_cnt_d   [N_BLOBS];
    logic             slot_done;

    logic ovf_q, ovf_d;

    logic [IDX_W-1:0] div_idx_q, div_idx_d;
    logic [K_W-1:0]   div_k_q, div_k_d;
    logic             div_active_q, div_active_d;
    logic [BIT_W-1:0] div_bits_q, div_bits_d;
    logic [ACC_W-1:0] div_den_q, div_den_d;
    logic [ACC_W-1:0] div_rem_h_q, div_rem_h_d, div_quo_h_q, div_quo_h_d;
    logic [ACC_W-1:0] div_rem_v_q, div_rem_v_d, div_quo_v_q, div_quo_v_d;
    logic [2*ACC_W-1:0] step_h, step_v;

    logic [W-1:0] stage_h_q [N_BLOBS];
    logic [W-1:0] stage_h_d [N_BLOBS];
    logic [W-1:0] stage_v_q [N_BLOBS];
    logic [W-1:0] stage_v_d [N_BLOBS];

    logic [N_BLOBS*W-1:0] pts_h_q, pts_h_d, pts_v_q, pts_v_d;
    logic [7:0]           num_q, num_d;
    logic                 fvalid_q, fvalid_d;
    logic                 ovf_out_q, ovf_out_d;

    assign hs_fall   = hs_q & ~VGA_HS;
    assign vs_fall   = vs_q & ~VGA_VS;
    assign flag_fall = flag_q & ~BINARY_FLAG;

    assign step_h = div_step(div_rem_h_q, div_quo_h_q, div_den_q);
    assign step_v = div_step(div_rem_v_q, div_quo_v_q, div_den_q);

    assign o_POINTS_H    = pts_h_q;
    assign o_POINTS_V    = pts_v_q;
    assign o_POINTS_NUM  = num_q;
    assign o_FRAME_VALID = fvalid_q;
    assign o_OVERFLOW    = ovf_out_q;
    assign o_BUSY        = (state_q == S_DIV) || (state_q == S_PUBLISH);

    // Next-state logic for the sequencer, run tracker, slots and dividers.
    always_comb begin
        state_d      = state_q;
        run_open_d   = run_open_q;
        run_rs_d     = run_rs_q;
        run_re_d     = run_re_q;
        run_v_d      = run_v_q;
        run_sum_h_d  = run_sum_h_q;
        run_sum_v_d  = run_sum_v_q;
        run_cnt_d    = run_cnt_q;
        slot_valid_d = slot_valid_q;
        slot_min_h_d = slot_min_h_q;
        slot_max_h_d = slot_max_h_q;
        slot_max_v_d = slot_max_v_q;
        slot_sum_h_d = slot_sum_h_q;
        slot_sum_v_d = slot_sum_v_q;
        slot_cnt_d   = slot_cnt_q;
        slot_done    = 1'b0;
        ovf_d        = ovf_q;
        div_idx_d    = div_idx_q;
        div_k_d      = div_k_q;
        div_active_d = div_active_q;
        div_bits_d   = div_bits_q;
        div_den_d    = div_den_q;
        div_rem_h_d  = div_rem_h_q;
        div_quo_h_d  = div_quo_h_q;
        div_rem_v_d  = div_rem_v_q;
        div_quo_v_d  = div_quo_v_q;
        stage_h_d    = stage_h_q;
        stage_v_d    = stage_v_q;
        pts_h_d      = pts_h_q;
        pts_v_d      = pts_v_q;
        num_d        = num_q;
        fvalid_d     = 1'b0;
        ovf_out_d    = ovf_out_q;

        case (state_q)
            S_SCAN: begin
                // Closing run: merge into the first matching slot, else allocate, else drop.
                if (run_open_q && (flag_fall || hs_fall || vs_fall)) begin
                    for (int i = 0; i < N_BLOBS; i++) begin
                        if (!slot_done && slot_valid_q[i]
                            && ((run_v_q - slot_max_v_q[i]) <= GAP_V)
                            && ({1'b0, run_rs_q} <= ({1'b0, slot_max_h_q[i]} + GAP_X))
                            && (({1'b0, run_re_q} + GAP_X) >= {1'b0, slot_min_h_q[i]})) begin
                            slot_done       = 1'b1;
                            slot_sum_h_d[i] = sat_add(slot_sum_h_q[i], run_sum_h_q);
                            slot_sum_v_d[i] = sat_add(slot_sum_v_q[i], run_sum_v_q);
                            slot_cnt_d[i]   = sat_add(slot_cnt_q[i], run_cnt_q);
                            if (run_rs_q < slot_min_h_q[i]) slot_min_h_d[i] = run_rs_q;
                            if (run_re_q > slot_max_h_q[i]) slot_max_h_d[i] = run_re_q;
                            slot_max_v_d[i] = run_v_q;
                        end
                    end
                    for (int i = 0; i < N_BLOBS; i++) begin
                        if (!slot_done && !slot_valid_q[i]) begin
                            slot_done       = 1'b1;
                            slot_valid_d[i] = 1'b1;
                            slot_sum_h_d[i] = run_sum_h_q;
                            slot_sum_v_d[i] = run_sum_v_q;
                            slot_cnt_d[i]   = run_cnt_q;
                            slot_min_h_d[i] = run_rs_q;
                            slot_max_h_d[i] = run_re_q;
                            slot_max_v_d[i] = run_v_q;
                        end
                    end
                    if (!slot_done) ovf_d = 1'b1;
                end

                // The frame-end pixel never opens a run, so nothing leaks past CLEAR.
                if (vs_fall) begin
                    run_open_d = 1'b0;
                    div_idx_d  = '0;
                    div_k_d    = '0;
                    state_d    = S_DIV;
                end else if (BINARY_FLAG) begin
                    if (!run_open_q || flag_fall || hs_fall) begin
                        run_open_d  = 1'b1;
                        run_rs_d    = H_CNT;
                        run_re_d    = H_CNT;
                        run_v_d     = V_CNT;
                        run_sum_h_d = ACC_W'(H_CNT);
                        run_sum_v_d = ACC_W'(V_CNT);
                        run_cnt_d   = ACC_W'(1);
                    end else begin
                        run_re_d    = H_CNT;
                        run_sum_h_d = sat_add(run_sum_h_q, ACC_W'(H_CNT));
                        run_sum_v_d = sat_add(run_sum_v_q, ACC_W'(V_CNT));
                        run_cnt_d   = sat_add(run_cnt_q, ACC_W'(1));
                    end
                end else begin
                    run_open_d = 1'b0;
                end
            end

            S_DIV: begin
                if (!div_active_q) begin
                    if (!slot_valid_q[div_idx_q] || (slot_cnt_q[div_idx_q] < MIN_CNT)) begin
                        if (div_idx_q == LAST_IDX) state_d = S_PUBLISH;
                        else div_idx_d = div_idx_q + 1'b1;
                    end else begin
                        div_active_d = 1'b1;
                        div_bits_d   = DIV_BITS;
                        div_den_d    = slot_cnt_q[div_idx_q];
                        div_rem_h_d  = '0;
                        div_rem_v_d  = '0;
                        div_quo_h_d  = slot_sum_h_q[div_idx_q];
                        div_quo_v_d  = slot_sum_v_q[div_idx_q];
                    end
                end else begin
                    {div_rem_h_d, div_quo_h_d} = step_h;
                    {div_rem_v_d, div_quo_v_d} = step_v;
                    div_bits_d = div_bits_q - 1'b1;
                    if (div_bits_q == BIT_W'(1)) begin
                        stage_h_d[div_k_q[IDX_W-1:0]] = step_h[W-1:0];
                        stage_v_d[div_k_q[IDX_W-1:0]] = step_v[W-1:0];
                        div_k_d      = div_k_q + 1'b1;
                        div_active_d = 1'b0;
                        if (div_idx_q == LAST_IDX) state_d = S_PUBLISH;
                        else div_idx_d = div_idx_q + 1'b1;
                    end
                end
            end

            S_PUBLISH: begin
                for (int k = 0; k < N_BLOBS; k++) begin
                    pts_h_d[k*W +: W] = (K_W'(k) < div_k_q) ? stage_h_q[k] : '0;
                    pts_v_d[k*W +: W] = (K_W'(k) < div_k_q) ? stage_v_q[k] : '0;
                end
                num_d     = 8'(div_k_q);
                ovf_out_d = ovf_q;
                fvalid_d  = 1'b1;
                state_d   = S_CLEAR;
            end

            S_CLEAR: begin
                for (int i = 0; i < N_BLOBS; i++) slot_valid_d[i] = 1'b0;
                ovf_d        = 1'b0;
                run_open_d   = 1'b0;
                div_active_d = 1'b0;
                state_d      = S_SCAN;
            end

            default: state_d = S_SCAN;
        endcase
    end

    // State, edge-detect copies and all datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_SCAN;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            flag_q       <= 1'b0;
            run_open_q   <= 1'b0;
            run_rs_q     <= '0;
            run_re_q     <= '0;
            run_v_q      <= '0;
            run_sum_h_q  <= '0;
            run_sum_v_q  <= '0;
            run_cnt_q    <= '0;
            for (int i = 0; i < N_BLOBS; i++) begin
                slot_valid_q[i] <= 1'b0;
                slot_min_h_q[i] <= '0;
                slot_max_h_q[i] <= '0;
                slot_max_v_q[i] <= '0;
                slot_sum_h_q[i] <= '0;
                slot_sum_v_q[i] <= '0;
                slot_cnt_q[i]   <= '0;
                stage_h_q[i]    <= '0;
                stage_v_q[i]    <= '0;
            end
            ovf_q        <= 1'b0;
            div_idx_q    <= '0;
            div_k_q      <= '0;
            div_active_q <= 1'b0;
            div_bits_q   <= '0;
            div_den_q    <= '0;
            div_rem_h_q  <= '0;
            div_quo_h_q  <= '0;
            div_rem_v_q  <= '0;
            div_quo_v_q  <= '0;
            pts_h_q      <= '0;
            pts_v_q      <= '0;
            num_q        <= '0;
            fvalid_q     <= 1'b0;
            ovf_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= VGA_HS;
            vs_q         <= VGA_VS;
            flag_q       <= BINARY_FLAG;
            run_open_q   <= run_open_d;
            run_rs_q     <= run_rs_d;
            run_re_q     <= run_re_d;
            run_v_q      <= run_v_d;
            run_sum_h_q  <= run_sum_h_d;
            run_sum_v_q  <= run_sum_v_d;
            run_cnt_q    <= run_cnt_d;
            slot_valid_q <= slot_valid_d;
            slot_min_h_q <= slot_min_h_d;
            slot_max_h_q <= slot_max_h_d;
            slot_max_v_q <= slot_max_v_d;
            slot_sum_h_q <= slot_sum_h_d;
            slot_sum_v_q <= slot_sum_v_d;
            slot_cnt_q   <= slot_cnt_d;
            stage_h_q    <= stage_h_d;
            stage_v_q    <= stage_v_d;
            ovf_q        <= ovf_d;
            div_idx_q    <= div_idx_d;
            div_k_q      <= div_k_d;
            div_active_q <= div_active_d;
            div_bits_q   <= div_bits_d;
            div_den_q    <= div_den_d;
            div_rem_h_q  <= div_rem_h_d;
            div_quo_h_q  <= div_quo_h_d;
            div_rem_v_q  <= div_rem_v_d;
            div_quo_v_q  <= div_quo_v_d;
            pts_h_q      <= pts_h_d;
            pts_v_q      <= pts_v_d;
            num_q        <= num_d;
            fvalid_q     <= fvalid_d;
            ovf_out_q    <= ovf_out_d;
        end
    end

endmodule

// File: doc/find_blob_centroids.md
# find_blob_centroids

Parametrised multi-blob centroid extractor for the thresholded camera stream. It sits after the binarisation stage, in the same position as the single-frame point finder, and consumes the same `BINARY_FLAG`/`H_CNT`/`V_CNT`/`VGA_HS`/`VGA_VS` stream. It groups lit pixels into up to `N_BLOBS` connected blobs using run-length merging with a configurable gap tolerance. At each frame end it computes every blob's truncated centroid with sequential dividers and publishes a compacted point list with a one-cycle valid strobe.

## Interface
- `N_BLOBS`, 4: number of blob slots and output points (1..16).
- `W`, 16: coordinate width.
- `ACC_W`, 32: width of the sum and pixel-count accumulators.
- `MERGE_GAP`, 2: max H/V pixel gap that still joins a run to a blob.
- `MIN_PIXELS`, 2: blobs with fewer pixels are discarded at frame end.
- `CLK` in 1: pixel clock; single clock domain.
- `RESET_N` in 1: asynchronous, active-low reset.
- `VGA_HS` in 1: line sync; the falling edge marks a new line.
- `VGA_VS` in 1: frame sync; the falling edge marks a new frame.
- `BINARY_FLAG` in 1: current pixel is lit.
- `H_CNT` in W: pixel column.
- `V_CNT` in W: pixel row.
- `o_POINTS_H` out N_BLOBS*W: centroid H values; point k is in bits [k*W +: W].
- `o_POINTS_V` out N_BLOBS*W: centroid V values, same packing.
- `o_POINTS_NUM` out 8: number of valid points in the published list.
- `o_FRAME_VALID` out 1: one-cycle strobe when a new list is published.
- `o_OVERFLOW` out 1: at least one run was dropped in the published frame.
- `o_BUSY` out 1: high while in DIV or PUBLISH.

## Operation
- States: SCAN, DIV, PUBLISH, CLEAR. Reset enters SCAN with all slots empty.
- Reset values: all outputs 0. Slots empty, internal edge registers 0.
- SCAN, run tracking:
  - A lit pixel with no open run opens a run: `rs = H_CNT`, `re = H_CNT`, the run's sums start from this pixel.
  - Each lit pixel adds `H_CNT` to `run_sum_h`, `V_CNT` to `run_sum_v`, and 1 to `run_cnt`. It also sets `re = H_CNT`.
- Run close: a run closes on a falling edge of `BINARY_FLAG`, a falling edge of `VGA_HS`, or a falling edge of `VGA_VS`.
- Matching a closed run at row `v`. A slot matches when all of the following hold:
  - The slot is valid.
  - `v - slot.max_v <= MERGE_GAP`.
  - `rs <= slot.max_h + MERGE_GAP`.
  - `re + MERGE_GAP >= slot.min_h`.
  - Comparisons are unsigned. Clamp `min_h - MERGE_GAP` at 0; do not wrap.
- Merge: the lowest-index matching slot absorbs the run.
  - The slot adds the run's sums and count.
  - `min_h`/`max_h` widen to include the run; `max_v = v`.
  - Other matching slots are not merged. This is an accepted limitation: U-shapes may yield two blobs.
- Allocate: with no match, the lowest-index empty slot is initialised from the run.
- Drop: with no match and no empty slot, the run is discarded and the frame's overflow flag is set.
- Accumulators saturate at all-ones; they do not wrap.
- Frame end: the `VGA_VS` falling edge closes and merges any open run in that cycle, then moves to DIV on the next cycle.
- DIV:
  - Slots are visited in index order 0..N_BLOBS-1.
  - An empty slot, or one with `cnt < MIN_PIXELS`, takes 1 cycle and is skipped.
  - A kept slot runs two parallel restoring dividers (`sum_h/cnt`, `sum_v/cnt`). Each divider is 1 bit per cycle over ACC_W cycles, plus 1 load cycle.
  - Each quotient is truncated to the low W bits and written to staging entry k, where k is the count of kept slots so far.
- PUBLISH: one cycle.
  - Staging entries 0..k-1 are copied to the outputs. Entries k..N_BLOBS-1 are zeroed.
  - `o_POINTS_NUM = k`; `o_OVERFLOW` is set from the frame flag; `o_FRAME_VALID = 1`.
- CLEAR: one cycle. Empties all slots and clears the frame overflow flag, then returns to SCAN.
- Outside SCAN, `BINARY_FLAG`, `VGA_HS` and `VGA_VS` edges are ignored, with one exception: edge-detect registers keep sampling, so no false edge fires on the return to SCAN.
- Reset mid-operation: in any state, the outputs and all slots clear asynchronously. No `o_FRAME_VALID` is issued for the interrupted frame.

## Timing
- Edge detection uses a single registered copy of each sync/flag input. An event is acted on in the cycle the falling edge is seen.
- Run-close-to-slot-update latency: 1 cycle. A run closing and a new run opening in the same cycle are both handled, with the close using the old run values.
- Frame latency, from the VS falling edge to `o_FRAME_VALID`: 1 + S + K·(ACC_W+1) + 1 cycles, where S is the number of skipped slots and K the number of kept slots.
  - Example: N_BLOBS=4, ACC_W=32, 2 kept blobs gives 1 + 2 + 66 + 1 = 70 cycles.
- Outputs hold their values until the next PUBLISH. `o_FRAME_VALID` is high for exactly one cycle, aligned with the new values.
- Total DIV+PUBLISH+CLEAR time must fit in vertical blanking: at most N_BLOBS·(ACC_W+1)+3 cycles.

## Test plan
- Reset check, defaults: assert `RESET_N=0` mid-DIV → outputs all 0 and `o_BUSY=0`. The next clean frame publishes normally.
- Single blob, defaults: lit 3×3 square at H 100..102, V 50..52 → `o_POINTS_NUM=1`, point 0 = (101,51), `o_OVERFLOW=0`. Strobe arrives exactly 1+3+33+1 = 38 cycles after VS falls.
- Gap merge, defaults: blob at H 10..11 on V 5, plus a run at H 13..13 on V 7 → one blob. Sums are H 34, V 17, count 3, so the point is (11,5).
- Separation and filtering, defaults: blobs at (20,20) and (200,100), each 2×2, plus an isolated single pixel at (300,300) → `o_POINTS_NUM=2` in slot order. The single pixel is discarded because 1 < MIN_PIXELS.
- Overflow, defaults: five disjoint 2×2 blobs on separate rows → `o_POINTS_NUM=4`, the first four blobs in raster order, `o_OVERFLOW=1`. The next frame with one blob publishes `o_OVERFLOW=0`.
- Frame-end edge case, defaults: `BINARY_FLAG` is still high on the last pixel when VS falls → the run is included in the centroid, and there is no false new run after CLEAR.
